// File: rtl/bexkat1_wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between NM masters.
// Optional watchdog on hung acks: define BEXKAT1_ARB_TIMEOUT_EN.
module bexkat1_wb_arbiter #(
    parameter int unsigned NM     = 2,
    parameter int unsigned MAXOUT = 4
`ifdef BEXKAT1_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NM-1:0]     m_cyc_i,
    input  logic [NM-1:0]     m_stb_i,
    input  logic [NM-1:0]     m_we_i,
    input  logic [4*NM-1:0]   m_sel_i,
    input  logic [32*NM-1:0]  m_adr_i,
    input  logic [32*NM-1:0]  m_dat_i,
    output logic [31:0]       m_dat_o,
    output logic [NM-1:0]     m_ack_o,
    output logic [NM-1:0]     m_stall_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic [31:0]       s_adr_o,
    output logic [31:0]       s_dat_o,
    input  logic [31:0]       s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_stall_i,
    output logic [NM-1:0]     grant_o,
    output logic              timeout_o
);

    localparam int unsigned GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        st_q, st_d;
    logic [GW-1:0] g_q, g_d;
    logic [GW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          busy;
    logic [GW-1:0] mi;
    logic          room;
    logic          accept;
    logic          ack_eff;
    logic          to_fire;
    logic [GW-1:0] pick;
    logic          any_req;

    // Reset forces the idle view of the bus even before the state register clears.
    assign busy    = (st_q == BUSY) && !rst_i;
    assign mi      = busy ? g_q : '0;
    assign room    = cnt_q < CW'(MAXOUT);
    assign s_cyc_o = busy & m_cyc_i[mi];
    assign s_stb_o = busy & m_stb_i[mi] & room;
    assign s_we_o  = m_we_i[mi];
    assign s_sel_o = m_sel_i[4*int'(mi) +: 4];
    assign s_adr_o = m_adr_i[32*int'(mi) +: 32];
    assign s_dat_o = m_dat_i[32*int'(mi) +: 32];
    assign accept  = s_stb_o & !s_stall_i;
    assign ack_eff = busy & s_ack_i & (cnt_q != '0);

    // Per-master routing of grant, ack and stall.
    always_comb begin
        grant_o   = '0;
        m_ack_o   = '0;
        m_stall_o = '1;
        m_dat_o   = to_fire ? 32'hFFFF_FFFF : s_dat_i;
        if (busy) begin
            grant_o[mi]   = 1'b1;
            m_ack_o[mi]   = s_ack_i | to_fire;
            m_stall_o[mi] = s_stall_i | !room;
        end
    end

    // First requester after the previous owner wins; offset NM (the previous owner) is last.
    always_comb begin
        int            sum;
        logic [GW-1:0] idx;
        pick    = last_q;
        any_req = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int i = int'(NM); i >= 1; i--) begin
            sum = int'(last_q) + i;
            idx = GW'(sum % int'(NM));
            if (m_cyc_i[idx]) begin
                pick    = idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        st_d   = st_q;
        g_d    = g_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        case (st_q)
            IDLE: begin
                if (any_req) begin
                    st_d   = BUSY;
                    g_d    = pick;
                    last_d = pick;
                end
            end
            BUSY: begin
                if (!m_cyc_i[g_q]) begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(accept) - CW'(ack_eff | to_fire);
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q   <= IDLE;
            g_q    <= '0;
            last_q <= GW'(NM - 1);
            cnt_q  <= '0;
        end else begin
            st_q   <= st_d;
            g_q    <= g_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef BEXKAT1_ARB_TIMEOUT_EN
    localparam int unsigned WW = 8;

    logic [WW-1:0] wd_q, wd_d;

    // Counts silent cycles with requests outstanding; fires a synthetic error ack.
    always_comb begin
        wd_d    = '0;
        to_fire = 1'b0;
        if (busy && m_cyc_i[g_q] && (cnt_q != '0) && !s_ack_i && !accept) begin
            if (wd_q == WW'(TIMEOUT - 1)) begin
                to_fire = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout_o = to_fire;
`else
    assign to_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bexkat1_wb_arbiter.sv
// Directed bench for bexkat1_wb_arbiter with NM=2, MAXOUT=4 (TIMEOUT=8 when the watchdog is built).
module tb_bexkat1_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [7:0]  m_sel_i;
    logic [63:0] m_adr_i, m_dat_i;
    logic [31:0] m_dat_o;
    logic [1:0]  m_ack_o, m_stall_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i, s_stall_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    logic        man_ack;
    logic        auto_en;
    logic [3:0]  pipe = 4'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bexkat1_wb_arbiter #(
        .NM(2),
        .MAXOUT(4)
`ifdef BEXKAT1_ARB_TIMEOUT_EN
        ,
        .TIMEOUT(8)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_stall_o(m_stall_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_stall_i(s_stall_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    // Slave model: acks each accepted request four edges later when enabled.
    always @(posedge clk) pipe <= {pipe[2:0], auto_en & s_stb_o & !s_stall_i};
    assign s_ack_i = auto_en ? pipe[3] : man_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m0_left, n_acc, acks0, acks1;
        rst_i     = 1'b1;
        m_cyc_i   = 2'b00;
        m_stb_i   = 2'b00;
        m_we_i    = 2'b10;
        m_sel_i   = 8'hCF;
        m_adr_i   = {32'h2000_0004, 32'h1000_0000};
        m_dat_i   = {32'hBBBB_0002, 32'hAAAA_0001};
        s_dat_i   = 32'hCAFE_0001;
        s_stall_i = 1'b1;
        man_ack   = 1'b0;
        auto_en   = 1'b0;

        // Reset state
        tick(); tick();
        #4;
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_stall", 32'(m_stall_o), 32'h3);
        check("rst_scyc", 32'(s_cyc_o), 32'h0);
        check("rst_timeout", 32'(timeout_o), 32'h0);
        check("rst_adr_m0", s_adr_o, 32'h1000_0000);

        // Both masters request together: master 0 wins first
        tick();
        rst_i   = 1'b0;
        m_cyc_i = 2'b11;
        m_stb_i = 2'b11;
        #4;
        check("t1_idle_grant", 32'(grant_o), 32'h0);
        check("t1_idle_sstb", 32'(s_stb_o), 32'h0);
        tick();
        s_stall_i = 1'b0;
        m_stb_i   = 2'b10;
        #4;
        check("t1_grant", 32'(grant_o), 32'h1);
        check("t1_stall", 32'(m_stall_o), 32'h2);
        check("t1_adr", s_adr_o, 32'h1000_0000);
        check("t1_sel", 32'(s_sel_o), 32'hF);
        check("t1_dat", m_dat_o, 32'hCAFE_0001);

        // Master 0 releases; master 1 gets the bus after one idle cycle
        tick();
        m_cyc_i = 2'b10;
        m_stb_i = 2'b00;
        #4;
        check("t3_rel_grant", 32'(grant_o), 32'h1);
        check("t3_rel_scyc", 32'(s_cyc_o), 32'h0);
        tick(); #4;
        check("t3_gap_grant", 32'(grant_o), 32'h0);
        check("t3_gap_stall", 32'(m_stall_o), 32'h3);
        tick(); #4;
        check("t3_m1_grant", 32'(grant_o), 32'h2);
        check("t3_m1_adr", s_adr_o, 32'h2000_0004);
        check("t3_m1_we", 32'(s_we_o), 32'h1);
        tick();
        m_cyc_i = 2'b11;
        #4;
        check("t3_no_preempt", 32'(grant_o), 32'h2);
        tick();
        m_cyc_i = 2'b01;
        #4;
        check("t3_m1_rel", 32'(grant_o), 32'h2);
        tick(); #4;
        check("t3_gap2", 32'(grant_o), 32'h0);
        tick(); #4;
        check("t3_rr_back", 32'(grant_o), 32'h1);

        // Six pipelined reads with MAXOUT=4 and late acks
        tick();
        auto_en = 1'b1;
        m0_left = 6; n_acc = 0; acks0 = 0; acks1 = 0;
        for (int c = 0; c < 16; c++) begin
            m_stb_i = {1'b0, m0_left != 0};
            #4;
            if (c == 4) begin
                check("t2_stall_full", 32'(m_stall_o[0]), 32'h1);
                check("t2_cnt_full", 32'(dut.cnt_q), 32'h4);
                check("t2_acc_before", 32'(n_acc), 32'h4);
            end
            if (m_ack_o[0]) acks0++;
            if (m_ack_o[1]) acks1++;
            if (m_stb_i[0] && !m_stall_o[0]) begin
                m0_left--;
                n_acc++;
            end
            tick();
        end
        check("t2_acks_m0", 32'(acks0), 32'h6);
        check("t2_acks_m1", 32'(acks1), 32'h0);
        check("t2_acc_total", 32'(n_acc), 32'h6);
        check("t2_cnt_end", 32'(dut.cnt_q), 32'h0);
        auto_en = 1'b0;

        // Accept and ack together hold cnt; spurious ack does not underflow
        m_stb_i = 2'b01;
        tick(); tick();
        man_ack = 1'b1;
        #4;
        check("t4_cnt2", 32'(dut.cnt_q), 32'h2);
        check("t4_ack_route", 32'(m_ack_o), 32'h1);
        tick();
        m_stb_i = 2'b00;
        #4;
        check("t4_acc_ack", 32'(dut.cnt_q), 32'h2);
        tick(); tick();
        #4;
        check("t4_cnt0", 32'(dut.cnt_q), 32'h0);
        tick();
        man_ack = 1'b0;
        #4;
        check("t4_no_underflow", 32'(dut.cnt_q), 32'h0);

        // Reset in the middle of a transfer with three outstanding
        tick();
        m_stb_i = 2'b01;
        tick(); tick(); tick();
        m_stb_i = 2'b00;
        #4;
        check("t5_cnt3", 32'(dut.cnt_q), 32'h3);
        tick();
        rst_i   = 1'b1;
        m_cyc_i = 2'b11;
        #4;
        check("t5_rst_grant", 32'(grant_o), 32'h0);
        tick();
        rst_i   = 1'b0;
        man_ack = 1'b1;
        #4;
        check("t5_grant", 32'(grant_o), 32'h0);
        check("t5_stall", 32'(m_stall_o), 32'h3);
        check("t5_ack_drop", 32'(m_ack_o), 32'h0);
        check("t5_cnt", 32'(dut.cnt_q), 32'h0);
        tick();
        man_ack = 1'b0;
        #4;
        check("t5_regrant_m0", 32'(grant_o), 32'h1);

`ifdef BEXKAT1_ARB_TIMEOUT_EN
        // One accepted read, silent slave: watchdog acks on the eighth cycle after
        tick();
        m_stb_i = 2'b01;
        tick();
        m_stb_i = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            #4;
            if (k == 7) check("wd_early", 32'(timeout_o), 32'h0);
            if (k == 8) begin
                check("wd_fire", 32'(timeout_o), 32'h1);
                check("wd_ack", 32'(m_ack_o), 32'h1);
                check("wd_dat", m_dat_o, 32'hFFFF_FFFF);
            end
            tick();
        end
        #4;
        check("wd_cnt0", 32'(dut.cnt_q), 32'h0);
        check("wd_once", 32'(timeout_o), 32'h0);
`else
        #4;
        check("wd_off", 32'(timeout_o), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
